// File: rtl/serial_cmd_rx_if.sv
// serial_cmd_rx_if: command output bus of the ALU serial command receiver.
//
// Handshake: the master raises cmd_valid with all fields registered and keeps
// them stable until a rising clk edge where cmd_valid & cmd_ready are both
// high; that edge is the transfer. cmd_ready may be held high without
// cmd_valid. The master never waits for cmd_ready before asserting cmd_valid.
//
// Signals:
//   cmd_valid  master->slave  command present in the output register
//   cmd_ready  slave->master  consumer accepts the command this cycle
//   b_data     master->slave  operand B (first operand on the wire), W bits
//   a_data     master->slave  operand A, W bits
//   opcode     master->slave  3-bit opcode from the control frame
//   err_data   master->slave  wrong data frame count or malformed control byte
//   err_crc    master->slave  received CRC-4 differs from computed CRC-4
//   err_frame  master->slave  a stop bit was 0; command aborted early
//   overrun    master->slave  one-cycle pulse: a finished command was dropped
interface serial_cmd_rx_if #(
  parameter int W = 32
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] b_data;
  logic [W-1:0] a_data;
  logic [2:0]   opcode;
  logic         err_data;
  logic         err_crc;
  logic         err_frame;
  logic         overrun;

  modport master (
    output cmd_valid, b_data, a_data, opcode, err_data, err_crc, err_frame,
           overrun,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, b_data, a_data, opcode, err_data, err_crc, err_frame,
           overrun,
    output cmd_ready
  );
endinterface

// File: rtl/serial_cmd_rx.sv
// serial_cmd_rx: receiver for the ALU serial command protocol.
//
// Each 11-bit frame is: start(0), type(0 data / 1 control), payload[7:0]
// MSB first, stop(1). DATA_BYTES data frames build operand B, the next
// DATA_BYTES build operand A, and a control frame {0, opcode[2:0], crc[3:0]}
// closes the command. The assembled command is offered on a single-entry
// valid/ready output register.
//
// Ports:
//   clk        clock, sin registered on the rising edge
//   rst_n      asynchronous active-low reset
//   sin        serial input, idles high
//   cmd        serial_cmd_rx_if.master command output bus
//   dbg_state  current receive FSM state (IDLE=0, TYPE=1, PAYLOAD=2, STOP=3)
module serial_cmd_rx #(
  parameter int DATA_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sin,
  serial_cmd_rx_if.master        cmd,
  output logic [1:0]             dbg_state
);
  localparam int W  = 8 * DATA_BYTES;
  localparam int FW = $clog2(2 * DATA_BYTES + 1);
  localparam logic [FW-1:0] FMAX = FW'(2 * DATA_BYTES);

  typedef enum logic [1:0] {IDLE, TYPE, PAYLOAD, STOP} state_t;

  state_t        state;
  logic          sin_q;     // sin is registered once; the FSM works on sin_q
  logic          is_ctrl;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [FW-1:0] fcnt;
  logic          data_bad;
  logic [W-1:0]  b_asm;
  logic [W-1:0]  a_asm;
  logic [3:0]    crc;

  logic complete;
  logic load;

  // One bit of the x^4+x+1 LFSR.
  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic b);
    crc_step = {c[2:0], 1'b0} ^ ((c[3] ^ b) ? 4'b0011 : 4'b0000);
  endfunction

  // A command ends on a good control stop bit or on any bad stop bit.
  assign complete  = (state == STOP) && (is_ctrl || !sin_q);
  assign load      = complete && (!cmd.cmd_valid || cmd.cmd_ready);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sin_q         <= 1'b1;
      is_ctrl       <= 1'b0;
      bit_cnt       <= 3'd0;
      shreg         <= 8'd0;
      fcnt          <= '0;
      data_bad      <= 1'b0;
      b_asm         <= '0;
      a_asm         <= '0;
      crc           <= 4'd0;
      cmd.cmd_valid <= 1'b0;
      cmd.b_data    <= '0;
      cmd.a_data    <= '0;
      cmd.opcode    <= 3'd0;
      cmd.err_data  <= 1'b0;
      cmd.err_crc   <= 1'b0;
      cmd.err_frame <= 1'b0;
      cmd.overrun   <= 1'b0;
    end else begin
      sin_q <= sin;

      case (state)
        IDLE: begin
          if (!sin_q) state <= TYPE;
        end
        TYPE: begin
          is_ctrl <= sin_q;
          bit_cnt <= 3'd7;
          state   <= PAYLOAD;
        end
        PAYLOAD: begin
          shreg <= {shreg[6:0], sin_q};
          if (!is_ctrl) begin
            crc <= crc_step(crc, sin_q);
          end else if (bit_cnt == 3'd7) begin
            // The control byte's bit 7 slot carries the constant 1 of the
            // CRC message, placed just ahead of the opcode bits.
            crc <= crc_step(crc, 1'b1);
          end else if (bit_cnt >= 3'd4) begin
            crc <= crc_step(crc, sin_q);
          end
          bit_cnt <= bit_cnt - 3'd1;
          if (bit_cnt == 3'd0) state <= STOP;
        end
        STOP: begin
          state <= IDLE;
          if (complete) begin
            fcnt     <= '0;
            data_bad <= 1'b0;
            b_asm    <= '0;
            a_asm    <= '0;
            crc      <= 4'd0;
          end else if (fcnt == FMAX) begin
            data_bad <= 1'b1;
          end else begin
            // Byte index counts down from the MSB byte of each operand.
            for (int i = 0; i < DATA_BYTES; i++) begin
              if (fcnt == FW'(DATA_BYTES - 1 - i)) b_asm[i*8 +: 8] <= shreg;
              if (fcnt == FW'(2 * DATA_BYTES - 1 - i)) a_asm[i*8 +: 8] <= shreg;
            end
            fcnt <= fcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        cmd.cmd_valid <= 1'b1;
        cmd.b_data    <= b_asm;
        cmd.a_data    <= a_asm;
        cmd.opcode    <= is_ctrl ? shreg[6:4] : 3'd0;
        cmd.err_frame <= !sin_q;
        cmd.err_data  <= sin_q && (data_bad || shreg[7] || (fcnt != FMAX));
        cmd.err_crc   <= sin_q && (shreg[3:0] != crc);
        cmd.overrun   <= 1'b0;
      end else begin
        cmd.overrun <= complete;
        if (cmd.cmd_ready) cmd.cmd_valid <= 1'b0;
      end
    end
  end
endmodule
